// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Multiplexed multi-digit 7-segment driver. Accepts a packed BCD
//            word over a valid/ready handshake into a shadow buffer, swaps it
//            into the displayed buffer only at frame boundaries, and scans one
//            digit per refresh slot with a blank guard cycle at slot start.
//            Codes 10..15 are blanked; leading zeros optionally blanked.
// Ports    : clk         - system clock, rising edge
//            reset       - asynchronous assert, active-low
//            load_valid  - bcd_in valid this cycle
//            load_ready  - shadow buffer free (load accepted on valid&&ready)
//            bcd_in      - digit i at [4i+3:4i], digit 0 least significant
//            blank_lz    - 1 = blank leading zeros (used live)
//            segments    - {g,f,e,d,c,b,a} active-high, 0 when blanked/guard
//            digit_en    - one-hot active-high digit select, 0 in guard cycle
//            frame_tick  - 1-cycle pulse in the last cycle of each frame
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 250
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    blank_lz,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_tick
);

    localparam int c_DIV_W  = $clog2(REFRESH_DIV);
    localparam int c_SLOT_W = $clog2(NUM_DIGITS);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(REFRESH_DIV - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(NUM_DIGITS - 1);

    logic [c_DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [c_SLOT_W-1:0]     slot_q,    slot_d;
    logic [4*NUM_DIGITS-1:0] shadow_q,  shadow_d;
    logic [4*NUM_DIGITS-1:0] active_q,  active_d;
    logic                    pending_q, pending_d;

    logic       w_div_wrap;
    logic       w_slot_last;
    logic       w_frame_end;
    logic       w_accept;
    logic       w_guard;
    logic       w_zero_run;
    logic       w_lead_zero;
    logic       w_blank;
    logic [3:0] w_digit;

    // Standard active-high decoder, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg7_decode = 7'h3F;
            4'd1:    seg7_decode = 7'h06;
            4'd2:    seg7_decode = 7'h5B;
            4'd3:    seg7_decode = 7'h4F;
            4'd4:    seg7_decode = 7'h66;
            4'd5:    seg7_decode = 7'h6D;
            4'd6:    seg7_decode = 7'h7D;
            4'd7:    seg7_decode = 7'h07;
            4'd8:    seg7_decode = 7'h7F;
            4'd9:    seg7_decode = 7'h6F;
            default: seg7_decode = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
            slot_q    <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            slot_q    <= slot_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    // Scan timing, handshake and frame-synchronous buffer swap.
    always_comb begin
        w_div_wrap  = (div_cnt_q == c_DIV_LAST);
        w_slot_last = (slot_q == c_SLOT_LAST);
        w_frame_end = w_div_wrap && w_slot_last;
        w_accept    = load_valid && !pending_q;

        div_cnt_d = w_div_wrap ? '0 : div_cnt_q + c_DIV_W'(1);
        slot_d    = slot_q;
        if (w_div_wrap) begin
            slot_d = w_slot_last ? '0 : slot_q + c_SLOT_W'(1);
        end

        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        // Accept needs pending=0 and transfer needs pending=1, so a word
        // captured on the frame_end cycle waits for the following frame_end.
        if (w_accept) begin
            shadow_d  = bcd_in;
            pending_d = 1'b1;
        end
        if (w_frame_end && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

    // Digit selection and blanking. Scanning from the most significant digit
    // down, w_zero_run stays high while every digit seen so far is zero.
    always_comb begin
        w_zero_run  = 1'b1;
        w_digit     = 4'd0;
        w_lead_zero = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (active_q[4*i +: 4] == 4'd0);
            if (c_SLOT_W'(i) == slot_q) begin
                w_digit     = active_q[4*i +: 4];
                w_lead_zero = w_zero_run && (i != 0);
            end
        end
        w_blank = (w_digit > 4'd9) || (blank_lz && w_lead_zero);
        // First cycle of each slot is dark to stop ghosting between digits.
        w_guard = (div_cnt_q == '0);

        digit_en   = w_guard ? '0 : (NUM_DIGITS'(1) << slot_q);
        segments   = (w_guard || w_blank) ? 7'd0 : seg7_decode(w_digit);
        frame_tick = w_frame_end;
        load_ready = !pending_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Self-checking bench for seg7_scan_driver (4 digits, 4-cycle slot).
//            A frame-level reference model derives expected outputs from the
//            elapsed cycle count since reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int R = 4;

    logic           clk;
    logic           reset;
    logic           load_valid;
    logic           load_ready;
    logic [4*N-1:0] bcd_in;
    logic           blank_lz;
    logic [6:0]     segments;
    logic [N-1:0]   digit_en;
    logic           frame_tick;

    int n_assert;
    int n_fail;

    // Reference model state
    int          m_t;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_pending;

    seg7_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .bcd_in     (bcd_in),
        .blank_lz   (blank_lz),
        .segments   (segments),
        .digit_en   (digit_en),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s t=%0d: observed=%0h expected=%0h", tag, m_t, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_t       = 0;
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
    endtask

    // Expected outputs from elapsed time and the displayed word.
    task automatic check_outputs();
        int phase, slot, digit, upper;
        logic [N-1:0] e_en;
        logic [6:0]   e_seg;
        logic         e_tick;
        phase  = m_t % R;
        slot   = (m_t / R) % N;
        upper  = int'(m_active) >> (4 * slot);
        digit  = upper & 15;
        e_tick = ((m_t % (N * R)) == (N * R - 1));
        e_en   = (phase == 0) ? '0 : N'(1 << slot);
        if (phase == 0 || digit > 9 || (blank_lz && slot > 0 && upper == 0))
            e_seg = 7'h00;
        else
            e_seg = seg_ref(digit);
        chk("digit_en",   32'(digit_en),   32'(e_en));
        chk("segments",   32'(segments),   32'(e_seg));
        chk("frame_tick", 32'(frame_tick), 32'(e_tick));
        chk("load_ready", 32'(load_ready), 32'(!m_pending));
    endtask

    // Check at negedge, advance the model by one clock, return just after posedge.
    task automatic cycle();
        logic frame_end;
        @(negedge clk);
        check_outputs();
        if (!reset) begin
            model_reset();
        end else begin
            frame_end = ((m_t % (N * R)) == (N * R - 1));
            if (frame_end && m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end else if (load_valid && !m_pending) begin
                m_shadow  = bcd_in;
                m_pending = 1'b1;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic load(input logic [15:0] w);
        load_valid = 1'b1;
        bcd_in     = w;
        cycle();
        load_valid = 1'b0;
        bcd_in     = $urandom;
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        load_valid = 1'b0;
        bcd_in     = '0;
        blank_lz   = 1'b0;
        model_reset();

        // 1: reset state, then an idle frame of zeros
        run(3);
        reset = 1'b1;
        run(16);

        // 2: load 0x1234 on the third cycle of a frame
        run(2);
        load(16'h1234);
        run(13 + 16);

        // 3: second word while the first is pending is dropped
        load(16'h8765);
        load_valid = 1'b1;
        bcd_in     = 16'h9999;
        run(3);
        load_valid = 1'b0;
        run(32);

        // 4: leading-zero blanking
        blank_lz = 1'b1;
        load(16'h0042);
        run(32);
        blank_lz = 1'b0;
        run(16);
        blank_lz = 1'b1;
        load(16'h0000);
        run(32);
        blank_lz = 1'b0;
        run(16);

        // 5: invalid code blanked on its own digit
        load(16'h0A05);
        run(32);

        // 6: reset mid-frame discards pending data
        run(16 - (m_t % 16));
        load(16'h5678);
        run(3);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        run(2);
        reset = 1'b1;
        run(20);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            logic [15:0] w;
            for (int d = 0; d < N; d++)
                w[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            load_valid = ($urandom_range(0, 9) < 3);
            bcd_in     = w;
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
            cycle();
        end
        load_valid = 1'b0;
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
